// File: rtl/aes_round_ctrl.sv
// Iterative AES round controller: loads a block, sequences NR rounds through an external datapath, holds the ciphertext.
// Latency: out_valid rises NR edges after the accept edge, throughput one block per NR+2 cycles with out_ready tied high.
// Backpressure: in_ready only in IDLE; DONE holds out_data until out_ready. Optional abort input under `AES_ABORT_EN.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   round_idx,
    input  logic [127:0] round_key,
    output logic [127:0] round_state,
    output logic         round_last,
    input  logic [127:0] round_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef AES_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ROUND = 2'b01,
        S_DONE  = 2'b10
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic         kill;

`ifdef AES_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE: begin
                // Abort in IDLE suppresses the accept even with in_valid high.
                if (!kill && in_valid) begin
                    state_d = in_data ^ round_key;
                    rnd_d   = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                if (kill) begin
                    fsm_d   = S_IDLE;
                    rnd_d   = 4'd0;
                    state_d = '0;
                end else begin
                    state_d = round_result;
                    // >= keeps the counter from ever walking past NR.
                    if (rnd_q >= NR_L) begin
                        fsm_d = S_DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (kill) begin
                    fsm_d   = S_IDLE;
                    rnd_d   = 4'd0;
                    state_d = '0;
                end else if (out_ready) begin
                    fsm_d = S_IDLE;
                    rnd_d = 4'd0;
                end
            end
            default: begin
                fsm_d   = S_IDLE;
                rnd_d   = 4'd0;
                state_d = '0;
            end
        endcase
    end

    assign in_ready    = (fsm_q == S_IDLE);
    assign out_valid   = (fsm_q == S_DONE);
    assign round_idx   = (fsm_q == S_ROUND) ? rnd_q : 4'd0;
    assign round_last  = (fsm_q == S_ROUND) && (rnd_q == NR_L);
    assign round_state = state_q;
    assign out_data    = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: models the external key schedule and round datapath, checks handshakes, timing and ciphertexts.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic [127:0] round_state;
    logic         round_last;
    logic [127:0] round_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_ABORT_EN
    logic         abort;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [16];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .round_idx(round_idx), .round_key(round_key),
        .round_state(round_state), .round_last(round_last), .round_result(round_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef AES_ABORT_EN
        , .abort(abort)
`endif
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] rkey_of(input logic [127:0] key, input int r);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, x0) ^ gmul(8'h03, x1) ^ x2 ^ x3;
                b[4*c+1] = x0 ^ gmul(8'h02, x1) ^ gmul(8'h03, x2) ^ x3;
                b[4*c+2] = x0 ^ x1 ^ gmul(8'h02, x2) ^ gmul(8'h03, x3);
                b[4*c+3] = gmul(8'h03, x0) ^ x1 ^ x2 ^ gmul(8'h02, x3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rkey_of(key, 0);
        for (int r = 1; r <= NR; r++) s = aes_round(s, rkey_of(key, r), r == NR);
        return s;
    endfunction

    // External key schedule and round datapath seen by the controller.
    assign round_key = rk[round_idx];
    always_comb round_result = aes_round(round_state, round_key, round_last);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [127:0] key);
        for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? rkey_of(key, r) : '0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctl"}, {in_ready, out_valid, round_last, round_idx}, 7'b1000000);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_round_state"}, round_state, '0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("wait_in_ready", in_ready, 1'b1);
    endtask

    task automatic encrypt(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp, input int hold);
        set_key(key);
        wait_ready();
        in_valid = 1'b1;
        in_data  = pt;
        chk("accept_ctl", {in_ready, out_valid, round_last, round_idx}, 7'b1000000);
        tick();
        for (int k = 1; k <= NR; k++) begin
            // Stray handshake inputs outside their states must be ignored.
            in_valid  = 1'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom);
            chk("round_ctl", {in_ready, out_valid, round_last, round_idx}, {2'b00, (k == NR), 4'(k)});
            tick();
        end
        chk("done_valid", {in_ready, out_valid}, 2'b01);
        chk("done_data", out_data, exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = ~pt;
            tick();
            chk("hold_ctl", {in_ready, out_valid}, 2'b01);
            chk("hold_data", out_data, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_handshake", {in_ready, out_valid}, 2'b10);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [3];
        logic [127:0] key, pt;
        int           acc_cyc [$];
        logic [127:0] exp_q [$];
        int           nout, cyc;
        logic         took;

        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5};
        tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 0};
        tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2};

        build_sbox();
        set_key('0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_ABORT_EN
        abort     = 1'b0;
`endif
        #3 rst_n = 1'b0;
        #2 check_reset_outs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outs("after_release");

        for (int i = 0; i < 3; i++) begin
            chk("model_kat", aes_enc(tbl[i].key, tbl[i].pt), tbl[i].ct);
            encrypt(tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].hold);
        end

        for (int i = 0; i < 6; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            encrypt(key, pt, aes_enc(key, pt), int'($urandom_range(0, 3)));
        end

        // Back-to-back: in_valid and out_ready held high, three blocks.
        key = tbl[1].key;
        set_key(key);
        wait_ready();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        nout      = 0;
        for (cyc = 0; cyc < 3*(NR+2) + 8; cyc++) begin
            took = in_valid && in_ready;
            if (took) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(aes_enc(key, in_data));
            end
            if (out_valid && exp_q.size() > 0) begin
                chk("b2b_data", out_data, exp_q.pop_front());
                nout++;
            end
            tick();
            if (took) in_data = {$urandom, $urandom, $urandom, $urandom};
            if (acc_cyc.size() == 3) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("b2b_accepts", acc_cyc.size(), 3);
        chk("b2b_outputs", nout, 3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_interval0", acc_cyc[1] - acc_cyc[0], NR + 2);
            chk("b2b_interval1", acc_cyc[2] - acc_cyc[1], NR + 2);
        end

        // Asynchronous reset in the middle of round 5.
        set_key(tbl[0].key);
        wait_ready();
        in_valid = 1'b1;
        in_data  = tbl[0].pt;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("pre_reset_round", round_idx, 4'd5);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("mid_round_reset");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NR + 3; k++) begin
            tick();
            chk("post_reset_idle", {in_ready, out_valid}, 2'b10);
        end
        encrypt(tbl[0].key, tbl[0].pt, tbl[0].ct, 1);

`ifdef AES_ABORT_EN
        set_key(tbl[0].key);
        wait_ready();
        in_valid = 1'b1;
        in_data  = tbl[0].pt;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_round", round_idx, 4'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_reset_outs("abort_idle");
        for (int k = 0; k < NR + 3; k++) begin
            tick();
            chk("abort_no_valid", out_valid, 1'b0);
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_no_accept", {in_ready, round_idx}, 5'b10000);
        tick();
        chk("abort_idle_still", in_ready, 1'b1);
        encrypt(tbl[0].key, tbl[0].pt, tbl[0].ct, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
